serial_magnitude_accumulator: RTL

- Consumes a stream of per-bit relation codes, MSB first, and accumulates them into one word-level relation for two operands of up to WIDTH bits.
- Each code uses the one-bit comparator encoding: [0]=EQ, [1]=LT (A<B), [2]=GT (A>B).
- Sits downstream of a one_bit_comparator instance in bit-serial datapaths, which gives word compare with no N-bit parallel tree.
- The result is held until a downstream valid/ready acceptance.

---
 rtl/cmp_pkg.sv | 27 ++
 rtl/rel_merge.sv | 34 +++
 rtl/serial_magnitude_accumulator.sv | 138 +++++++++++++
 3 files changed

// File: rtl/cmp_pkg.sv
// Shared definitions for the bit-serial magnitude compare path.
// Relation codes use the one_bit_comparator one-hot encoding:
// [0]=EQ, [1]=LT (A<B), [2]=GT (A>B).
// This file has no ports.
package cmp_pkg;

  localparam logic [2:0] REL_EQ   = 3'b001;
  localparam logic [2:0] REL_LT   = 3'b010;
  localparam logic [2:0] REL_GT   = 3'b100;
  localparam logic [2:0] REL_NONE = 3'b000;

  localparam int unsigned REL_EQ_B = 0;
  localparam int unsigned REL_LT_B = 1;
  localparam int unsigned REL_GT_B = 2;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    HOLD
  } state_e;

  // A code is legal only when exactly one relation bit is set.
  function automatic logic rel_onehot_ok(input logic [2:0] code);
    return (code == REL_EQ) || (code == REL_LT) || (code == REL_GT);
  endfunction

endpackage

// File: rtl/rel_merge.sv
// Combinational merge of one per-bit relation code into the running word relation.
// Ports:
//   run_i       running word relation so far
//   rel_i       incoming per-bit relation code
//   first_i     first beat of a word (running value is ignored)
//   lsb_first_i 1: codes arrive LSB first, 0: MSB first
//   run_o       next running relation
//   illegal_o   rel_i is not exactly one-hot
module rel_merge
  import cmp_pkg::*;
(
  input  logic [2:0] run_i,
  input  logic [2:0] rel_i,
  input  logic       first_i,
  input  logic       lsb_first_i,
  output logic [2:0] run_o,
  output logic       illegal_o
);

  always_comb begin
    illegal_o = ~rel_onehot_ok(rel_i);
    run_o     = run_i;
    if (first_i) begin
      run_o = rel_i;
    end else if (lsb_first_i) begin
      // Later beats are more significant, so any decision overrides.
      if (rel_i != REL_EQ) run_o = rel_i;
    end else begin
      // The most significant differing bit decides; only EQ can still change.
      if (run_i == REL_EQ) run_o = rel_i;
    end
  end

endmodule

// File: rtl/serial_magnitude_accumulator.sv
// Accumulates a stream of per-bit relation codes into one word relation and
// holds it until accepted downstream (valid/ready).
// Optional build macro SMA_LSB_FIRST_EN: codes arrive LSB first (default MSB first).
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   in_valid/ready  per-bit code handshake; in_rel one-hot {GT,LT,EQ}
//   in_last         final beat of the word
//   out_valid/ready word result handshake
//   out_rel         word relation {GT,LT,EQ}, 000 when out_err
//   out_err         illegal code seen or word overflow
//   out_nbits       beats consumed for this word
module serial_magnitude_accumulator
  import cmp_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_rel,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2:0]       out_rel,
  output logic             out_err,
  output logic [CNT_W-1:0] out_nbits
);

`ifdef SMA_LSB_FIRST_EN
  localparam logic LsbFirst = 1'b1;
`else
  localparam logic LsbFirst = 1'b0;
`endif

  state_e           state_q, state_d;
  logic [2:0]       run_q, run_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             out_valid_q, out_valid_d;
  logic [2:0]       out_rel_q, out_rel_d;
  logic             out_err_q, out_err_d;
  logic [CNT_W-1:0] out_nbits_q, out_nbits_d;

  logic             beat;
  logic             first;
  logic [2:0]       run_merged;
  logic             illegal;
  logic [CNT_W-1:0] cnt_inc;
  logic             at_width;

  assign in_ready  = (state_q != HOLD);
  assign beat      = in_valid & in_ready;
  assign first     = (state_q == IDLE);
  assign cnt_inc   = first ? CNT_W'(1) : cnt_q + CNT_W'(1);
  assign at_width  = (cnt_inc == CNT_W'(WIDTH));

  rel_merge u_rel_merge (
    .run_i       (run_q),
    .rel_i       (in_rel),
    .first_i     (first),
    .lsb_first_i (LsbFirst),
    .run_o       (run_merged),
    .illegal_o   (illegal)
  );

  always_comb begin
    state_d     = state_q;
    run_d       = run_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    out_valid_d = out_valid_q;
    out_rel_d   = out_rel_q;
    out_err_d   = out_err_q;
    out_nbits_d = out_nbits_q;
    case (state_q)
      IDLE, ACCUM: begin
        if (beat) begin
          run_d = run_merged;
          cnt_d = cnt_inc;
          // Reaching WIDTH without in_last is an overflow.
          err_d = (first ? 1'b0 : err_q) | illegal | (at_width & ~in_last);
          if (in_last || at_width) begin
            state_d     = HOLD;
            out_valid_d = 1'b1;
            out_rel_d   = err_d ? REL_NONE : run_d;
            out_err_d   = err_d;
            out_nbits_d = cnt_d;
          end else begin
            state_d = ACCUM;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d     = IDLE;
          run_d       = REL_EQ;
          cnt_d       = '0;
          err_d       = 1'b0;
          out_valid_d = 1'b0;
          out_rel_d   = REL_NONE;
          out_err_d   = 1'b0;
          out_nbits_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      run_q       <= REL_EQ;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_rel_q   <= REL_NONE;
      out_err_q   <= 1'b0;
      out_nbits_q <= '0;
    end else begin
      state_q     <= state_d;
      run_q       <= run_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
      out_rel_q   <= out_rel_d;
      out_err_q   <= out_err_d;
      out_nbits_q <= out_nbits_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_rel   = out_rel_q;
  assign out_err   = out_err_q;
  assign out_nbits = out_nbits_q;

endmodule
